// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes used by alu_decoder and alu_exec_unit, plus the default datapath width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SRL = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_e;

  function automatic logic is_shift(alu_op_e op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Bit-serial shifter: load captures value, amount and shift type; each step moves the value by one bit.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEFAULT,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  alu_op_e            op,
  input  logic [XLEN-1:0]    value,
  input  logic [SHAMT_W-1:0] amount,
  output logic [XLEN-1:0]    shifted,
  output logic               done
);

  logic [XLEN-1:0]    acc;
  logic [SHAMT_W-1:0] cnt;
  alu_op_e            op_q;

  // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    shifted = acc << 1;
    case (op_q)
      ALU_SRL: shifted = acc >> 1;
      ALU_SRA: shifted = {acc[XLEN-1], acc[XLEN-1:1]};
      default: shifted = acc << 1;
    endcase
  end

  // The step that consumes the last count produces the final value.
  assign done = step && (cnt == SHAMT_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the accumulator is reset as well so nothing from a discarded operation survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      cnt  <= '0;
      op_q <= ALU_SLL;
    end else if (load) begin
      acc  <= value;
      cnt  <= amount;
      op_q <= op;
    end else if (step) begin
      acc  <= shifted;
      cnt  <= cnt - SHAMT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle execute stage: single-cycle logic/arith ops and bit-serial shifts behind valid/ready handshakes.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter  int XLEN    = XLEN_DEFAULT,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state, state_next;
  alu_op_e            op;
  logic [SHAMT_W-1:0] amount;
  logic               accept;
  logic               long_shift;
  logic [XLEN-1:0]    alu_value;
  logic [XLEN-1:0]    shifted;
  logic               shift_done;

  assign op         = alu_op_e'(alu_control);
  assign amount     = src_b[SHAMT_W-1:0];
  assign in_ready   = (state == S_IDLE);
  assign accept     = in_valid && in_ready;
  assign long_shift = is_shift(op) && (amount != '0);
  assign out_valid  = (state == S_DONE);
  assign busy       = (state != S_IDLE);

  // Zero-amount shifts pass src_a straight through; unknown codes fall back to ADD like the decoder.
  always_comb begin
    alu_value = src_a + src_b;
    case (op)
      ALU_AND: alu_value = src_a & src_b;
      ALU_OR:  alu_value = src_a | src_b;
      ALU_SUB: alu_value = src_a - src_b;
      ALU_SLT: alu_value = XLEN'($signed(src_a) < $signed(src_b));
      ALU_SLL, ALU_SRL, ALU_SRA: alu_value = src_a;
      default: alu_value = src_a + src_b;
    endcase
  end

  alu_shift_iter #(.XLEN(XLEN)) u_shift (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept && long_shift),
    .step    (state == S_SHIFT),
    .op      (op),
    .value   (src_a),
    .amount  (amount),
    .shifted (shifted),
    .done    (shift_done)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = long_shift ? S_SHIFT : S_DONE;
      S_SHIFT: if (shift_done) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      result <= '0;
      zero   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept && !long_shift) begin
        result <= alu_value;
        zero   <= (alu_value == '0);
      end else if (shift_done) begin
        result <= shifted;
        zero   <= (shifted == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table, random ops against a reference model, corner sequences.
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      alu_control;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model straight from the op table: plain arithmetic, shifts done in one go.
  function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned amt;
    amt = b[4:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b0011: return a << amt;
      4'b0100: return a >> amt;
      4'b0101: return $signed(a) >>> amt;
      default: return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [31:0] b);
    if ((op == 4'b0011 || op == 4'b0100 || op == 4'b0101) && b[4:0] != 5'd0)
      return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Offer one op from a negedge, scramble inputs after the accept edge, count edges until out_valid.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic z, output int lat, output int ready_leak);
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    alu_control = 4'($urandom);
    src_a       = $urandom;
    src_b       = $urandom;
    lat         = 1;
    ready_leak  = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) ready_leak++;
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    z   = zero;
    @(negedge clk);
  endtask

  task automatic check_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] res, exp_res;
    logic        z;
    int          lat, leak;
    exp_res = ref_result(op, a, b);
    run_op(op, a, b, res, z, lat, leak);
    check({name, " result"}, res, exp_res);
    check({name, " zero"}, 32'(z), 32'(exp_res == 32'd0));
    check({name, " latency"}, 32'(lat), 32'(ref_latency(op, b)));
    check({name, " in_ready while busy"}, 32'(leak), 32'd0);
    @(posedge clk); #1;
    check({name, " in_ready after"}, 32'(in_ready), 32'd1);
    @(negedge clk);
  endtask

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] res;
    logic        z;
    int          lat, leak, stale;

    vecs.push_back('{"add 5+7",     4'b0010, 32'd5,        32'd7,        32'd12,         1'b0, 1});
    vecs.push_back('{"sub 9-9",     4'b0110, 32'd9,        32'd9,        32'd0,          1'b1, 1});
    vecs.push_back('{"slt -1<1",    4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,          1'b0, 1});
    vecs.push_back('{"add wrap",    4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,          1'b1, 1});
    vecs.push_back('{"sra 4",       4'b0101, 32'h80000000, 32'h00000024, 32'hF8000000,   1'b0, 5});
    vecs.push_back('{"sll 0",       4'b0011, 32'h1,        32'd0,        32'h1,          1'b0, 1});
    vecs.push_back('{"srl 31",      4'b0100, 32'h80000000, 32'd31,       32'h1,          1'b0, 32});
    vecs.push_back('{"or",          4'b0001, 32'hF0F00000, 32'h0000F0F0, 32'hF0F0F0F0,   1'b0, 1});
    vecs.push_back('{"slt 1<-1",    4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,          1'b1, 1});
    vecs.push_back('{"code 1000",   4'b1000, 32'd100,      32'd23,       32'd123,        1'b0, 1});
    vecs.push_back('{"sll 1",       4'b0011, 32'h80000001, 32'hFFFFFFE1, 32'h00000002,   1'b0, 2});

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; src_a = '0; src_b = '0;
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", result, 32'd0);
    check("reset zero", 32'(zero), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, z, lat, leak);
      check({vecs[i].name, " result"}, res, vecs[i].exp_res);
      check({vecs[i].name, " zero"}, 32'(z), 32'(vecs[i].exp_zero));
      check({vecs[i].name, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
      check({vecs[i].name, " in_ready while busy"}, 32'(leak), 32'd0);
      @(posedge clk); #1;
      check({vecs[i].name, " in_ready after"}, 32'(in_ready), 32'd1);
      @(negedge clk);
    end

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      logic [3:0]  op;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if (i % 5 == 0) a = b;
      check_op($sformatf("rand%0d op%0h", i, op), op, a, b);
    end

    // Backpressure: result held while out_ready is low; a waiting op is taken only after the drain edge.
    out_ready = 1'b0;
    run_op(4'b0000, 32'hF0, 32'h3C, res, z, lat, leak);
    check("bp first result", res, 32'h30);
    in_valid = 1'b1; alu_control = 4'b0010; src_a = 32'd1; src_b = 32'd1;
    for (int c = 0; c < 10; c++) begin
      check($sformatf("bp hold result c%0d", c), result, 32'h30);
      check($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
      check($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp drained valid", 32'(out_valid), 32'd0);
    check("bp drained in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("bp second valid", 32'(out_valid), 32'd1);
    check("bp second result", result, 32'd2);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("bp second drained", 32'(out_valid), 32'd0);
    @(negedge clk);

    // Reset during a long shift discards it.
    in_valid = 1'b1; alu_control = 4'b0011; src_a = 32'h1; src_b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("mid busy before reset", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset result", result, 32'd0);
    check("mid reset busy", 32'(busy), 32'd0);
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("no stale result", 32'(stale), 32'd0);
    check_op("post reset add", 4'b0010, 32'd2, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
